// File: rtl/target_hit_detect_pkg.sv
// Shared definitions for the target overlay: FSM encoding, screen geometry,
// pixel-bus struct and an interval-overlap helper.
package target_hit_detect_pkg;

  localparam logic [1:0] ST_MOVE    = 2'b00;
  localparam logic [1:0] ST_FLASH   = 2'b01;
  localparam logic [1:0] ST_RESPAWN = 2'b10;

  localparam int SCREEN_W_PX = 800;
  localparam int SCREEN_H_PX = 600;

  localparam logic [11:0] PROJ_COLOR = 12'hf00;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        h_sync;
    logic        v_sync;
    logic        h_blank;
    logic        v_blank;
    logic [11:0] rgb;
  } vid_t;

  // Closed intervals [a_lo,a_hi] and [b_lo,b_hi] share at least one point.
  function automatic logic span_overlap(input logic [12:0] a_lo, input logic [12:0] a_hi,
                                        input logic [12:0] b_lo, input logic [12:0] b_hi);
    return (a_hi >= b_lo) && (a_lo <= b_hi);
  endfunction

endpackage

// File: rtl/target_hit_detect_if.sv
// Pixel/timing bus between stages of the VGA overlay chain.
// The master drives the bundle, the slave consumes it; no handshake.
interface target_hit_detect_if;
  import target_hit_detect_pkg::*;

  vid_t dat;

  modport master (output dat);
  modport slave  (input  dat);
endinterface

// File: rtl/target_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), seed 8'h5A, advances when step is high.
// Output is the registered value; no backpressure.
module target_lfsr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  output logic [7:0] lfsr
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (step) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= 8'h5A;
    else        lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/target_hit_detect.sv
// Bouncing target overlay with once-per-frame projectile hit test; pixel and timing pass with 1-clock latency,
// free-running stream with no backpressure. Define TARGET_LFSR_EN to randomise the respawn x.
module target_hit_detect
  import target_hit_detect_pkg::*;
#(
  parameter int          SCREEN_W       = SCREEN_W_PX,
  parameter int          TARGET_W       = 32,
  parameter int          TARGET_H       = 16,
  parameter int          TARGET_Y       = 40,
  parameter int          TARGET_START_X = 384,
  parameter int          SPEED          = 2,
  parameter int          FLASH_FRAMES   = 30,
  parameter logic [11:0] TARGET_COLOR   = 12'h0f0,
  parameter logic [11:0] FLASH_COLOR    = 12'hfff
) (
  input  logic                clk,
  input  logic                rst_n,
  target_hit_detect_if.slave  vid_in,
  target_hit_detect_if.master vid_out,
  input  logic                bullet_active,
  input  logic [11:0]         bullet_x,
  input  logic [11:0]         bullet_y,
  output logic                hit,
  output logic [7:0]          score,
  output logic [11:0]         target_x
);

  localparam int          FCW       = $clog2(FLASH_FRAMES + 1);
  localparam logic [12:0] X_SPAN    = 13'(TARGET_W - 1);
  localparam logic [12:0] Y_TOP     = 13'(TARGET_Y);
  localparam logic [12:0] Y_BOT     = 13'(TARGET_Y + TARGET_H - 1);
  localparam logic [12:0] EDGE_PAD  = 13'(TARGET_W + SPEED);
  localparam logic [12:0] SCREEN_R  = 13'(SCREEN_W);

  logic [1:0]     state_q, state_d;
  logic           dir_left_q, dir_left_d;
  logic [11:0]    tx_q, tx_d;
  logic [FCW-1:0] flash_cnt_q, flash_cnt_d;
  logic [7:0]     score_q, score_d;
  logic           hit_q, hit_d;
  vid_t           vid_q, vid_d;

  logic        tick, overlap, in_box;
  logic [12:0] tx_w, bx_w, by_w, h_w, v_w;
  logic [11:0] respawn_x;

  assign tick = (vid_in.dat.hcount == 11'd0) && (vid_in.dat.vcount == 11'd0);
  assign tx_w = {1'b0, tx_q};
  assign bx_w = {1'b0, bullet_x};
  assign by_w = {1'b0, bullet_y};
  assign h_w  = {2'b0, vid_in.dat.hcount};
  assign v_w  = {2'b0, vid_in.dat.vcount};

  // 13-bit arithmetic so bullet_x+3 and tx+W-1 never wrap.
  assign overlap = span_overlap(bx_w, bx_w + 13'd3, tx_w, tx_w + X_SPAN) &&
                   span_overlap(by_w, by_w + 13'd3, Y_TOP, Y_BOT);
  assign in_box  = span_overlap(h_w, h_w, tx_w, tx_w + X_SPAN) &&
                   span_overlap(v_w, v_w, Y_TOP, Y_BOT);

`ifdef TARGET_LFSR_EN
  logic [7:0] lfsr_val;

  target_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (tick),
    .lfsr  (lfsr_val)
  );

  assign respawn_x = {4'b0, lfsr_val} + 12'd100;
`else
  assign respawn_x = 12'(TARGET_START_X);
`endif

  always_comb begin
    state_d     = state_q;
    dir_left_d  = dir_left_q;
    tx_d        = tx_q;
    flash_cnt_d = flash_cnt_q;
    score_d     = score_q;
    hit_d       = 1'b0;
    if (tick) begin
      case (state_q)
        ST_MOVE: begin
          // A hit freezes the target where it was struck.
          if (bullet_active && overlap) begin
            hit_d       = 1'b1;
            score_d     = (score_q == 8'hff) ? score_q : score_q + 8'd1;
            flash_cnt_d = FCW'(FLASH_FRAMES - 1);
            state_d     = ST_FLASH;
          end else if (!dir_left_q) begin
            if (tx_w + EDGE_PAD >= SCREEN_R) begin
              tx_d       = 12'(SCREEN_W - TARGET_W);
              dir_left_d = 1'b1;
            end else begin
              tx_d = tx_q + 12'(SPEED);
            end
          end else begin
            if (tx_q < 12'(SPEED)) begin
              tx_d       = 12'd0;
              dir_left_d = 1'b0;
            end else begin
              tx_d = tx_q - 12'(SPEED);
            end
          end
        end
        ST_FLASH: begin
          if (flash_cnt_q == '0) state_d = ST_RESPAWN;
          else                   flash_cnt_d = flash_cnt_q - 1'b1;
        end
        ST_RESPAWN: begin
          tx_d       = respawn_x;
          dir_left_d = ~dir_left_q;
          state_d    = ST_MOVE;
        end
        default: state_d = ST_MOVE;
      endcase
    end
  end

  always_comb begin
    vid_d = vid_in.dat;
    if (!vid_in.dat.h_blank && !vid_in.dat.v_blank && in_box) begin
      if (state_q == ST_MOVE)       vid_d.rgb = TARGET_COLOR;
      else if (state_q == ST_FLASH) vid_d.rgb = FLASH_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_MOVE;
      dir_left_q  <= 1'b0;
      tx_q        <= 12'(TARGET_START_X);
      flash_cnt_q <= '0;
      score_q     <= 8'd0;
      hit_q       <= 1'b0;
      vid_q       <= '0;
    end else begin
      state_q     <= state_d;
      dir_left_q  <= dir_left_d;
      tx_q        <= tx_d;
      flash_cnt_q <= flash_cnt_d;
      score_q     <= score_d;
      hit_q       <= hit_d;
      vid_q       <= vid_d;
    end
  end

  assign vid_out.dat = vid_q;
  assign hit         = hit_q;
  assign score       = score_q;
  assign target_x    = tx_q;

endmodule

// File: tb/tb_target_hit_detect.sv
// Directed bench for target_hit_detect: a frame-level reference model checked every clock,
// plus literal expectations for reset, bounce, hit/flash/respawn, near miss, saturation and mid-flash reset.
module tb_target_hit_detect;

  localparam int SCR_W = 800, TW = 32, TH = 16, TY = 40, START_X = 384, SPD = 2, FLASH_N = 30;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bullet_active;
  logic [11:0] bullet_x, bullet_y;
  logic        hit;
  logic [7:0]  score;
  logic [11:0] target_x;

  target_hit_detect_if vin ();
  target_hit_detect_if vout ();

  target_hit_detect dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .vid_in        (vin.slave),
    .vid_out       (vout.master),
    .bullet_active (bullet_active),
    .bullet_x      (bullet_x),
    .bullet_y      (bullet_y),
    .hit           (hit),
    .score         (score),
    .target_x      (target_x)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  // Reference model: frame-level game rules, advanced once per tick.
  string m_phase;
  int    m_x, m_left, m_flash_left, m_score;
  bit    m_valid = 1'b0;
  int    e_hit, e_rgb, e_h, e_v, e_hs, e_vs, e_hb, e_vb;

  always @(posedge clk) begin
    int h, v, bx, by;
    bit box, collide;
    h  = int'(vin.dat.hcount);
    v  = int'(vin.dat.vcount);
    bx = int'(bullet_x);
    by = int'(bullet_y);
    if (!rst_n) begin
      m_valid = 1'b1;
      m_phase = "move"; m_x = START_X; m_left = 0; m_flash_left = 0; m_score = 0;
      e_hit = 0; e_rgb = 0; e_h = 0; e_v = 0; e_hs = 0; e_vs = 0; e_hb = 0; e_vb = 0;
    end else begin
      e_h = h; e_v = v;
      e_hs = int'(vin.dat.h_sync); e_vs = int'(vin.dat.v_sync);
      e_hb = int'(vin.dat.h_blank); e_vb = int'(vin.dat.v_blank);
      box = (h >= m_x) && (h < m_x + TW) && (v >= TY) && (v < TY + TH);
      e_rgb = int'(vin.dat.rgb);
      if (!vin.dat.h_blank && !vin.dat.v_blank && box) begin
        if (m_phase == "move")  e_rgb = 'h0f0;
        if (m_phase == "flash") e_rgb = 'hfff;
      end
      e_hit = 0;
      if (h == 0 && v == 0) begin
        if (m_phase == "move") begin
          collide = bullet_active && (bx + 3 >= m_x) && (bx <= m_x + TW - 1) &&
                    (by + 3 >= TY) && (by <= TY + TH - 1);
          if (collide) begin
            e_hit = 1;
            if (m_score < 255) m_score++;
            m_phase = "flash";
            m_flash_left = FLASH_N;
          end else if (m_left == 0) begin
            if (m_x + TW + SPD >= SCR_W) begin m_x = SCR_W - TW; m_left = 1; end
            else m_x += SPD;
          end else begin
            if (m_x < SPD) begin m_x = 0; m_left = 0; end
            else m_x -= SPD;
          end
        end else if (m_phase == "flash") begin
          m_flash_left--;
          if (m_flash_left == 0) m_phase = "respawn";
        end else begin
          m_phase = "move";
          m_x = START_X;
          m_left = 1 - m_left;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("hit",         int'(hit), e_hit);
      check("score",       int'(score), m_score);
      check("target_x",    int'(target_x), m_x);
      check("rgb_out",     int'(vout.dat.rgb), e_rgb);
      check("hcount_out",  int'(vout.dat.hcount), e_h);
      check("vcount_out",  int'(vout.dat.vcount), e_v);
      check("h_sync_out",  int'(vout.dat.h_sync), e_hs);
      check("v_sync_out",  int'(vout.dat.v_sync), e_vs);
      check("h_blank_out", int'(vout.dat.h_blank), e_hb);
      check("v_blank_out", int'(vout.dat.v_blank), e_vb);
    end
  end

  int last_rgb;

  task automatic pix(input int h, input int v, input bit hb, input bit vb);
    vin.dat.hcount  = 11'(h);
    vin.dat.vcount  = 11'(v);
    vin.dat.h_sync  = 1'($urandom_range(0, 1));
    vin.dat.v_sync  = 1'($urandom_range(0, 1));
    vin.dat.h_blank = hb;
    vin.dat.v_blank = vb;
    last_rgb        = int'($urandom_range(0, 'h0ef));
    vin.dat.rgb     = 12'(last_rgb);
    @(negedge clk);
  endtask

  // Tick plus pixels around the target's edges, one inside a blanking interval.
  task automatic frame();
    pix(0, 0, 1'b0, 1'b0);
    pix(m_x, TY, 1'b0, 1'b0);
    pix(m_x + TW - 1, TY + TH - 1, 1'b0, 1'b0);
    pix(m_x + TW, TY, 1'b0, 1'b0);
    pix(m_x, TY - 1, 1'b0, 1'b0);
    pix(m_x + 5, TY + 5, 1'b1, 1'b0);
    pix(m_x + 6, TY + 6, 1'b0, 1'b1);
  endtask

  task automatic fast_frame();
    pix(0, 0, 1'b0, 1'b0);
    pix(100, 100, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    bullet_active = 1'b0;
    bullet_x = 12'd0;
    bullet_y = 12'd45;
    vin.dat = '0;
    @(negedge clk);
    pix(5, 5, 1'b0, 1'b0);
    pix(6, 5, 1'b0, 1'b0);
    check("reset_x", int'(target_x), 384);
    check("reset_score", int'(score), 0);
    check("reset_rgb", int'(vout.dat.rgb), 0);
    check("reset_hit", int'(hit), 0);
    rst_n = 1'b1;

    for (int n = 1; n <= 10; n++) begin
      frame();
      check("move_x", int'(target_x), 384 + 2 * n);
    end

    for (int n = 0; n < 181; n++) fast_frame();
    check("pre_bounce_x", int'(target_x), 766);
    frame();
    check("bounce_x", int'(target_x), 768);
    frame();
    check("after_bounce_x", int'(target_x), 766);

    bullet_active = 1'b1;
    bullet_x = 12'd776;
    bullet_y = 12'd45;
    pix(0, 0, 1'b0, 1'b0);
    check("hit_pulse", int'(hit), 1);
    bullet_active = 1'b0;
    pix(10, 10, 1'b0, 1'b0);
    check("hit_once", int'(hit), 0);
    check("hit_score", int'(score), 1);
    for (int n = 1; n < 30; n++) begin
      pix(0, 0, 1'b0, 1'b0);
      pix(766, 40, 1'b0, 1'b0);
      check("flash_pix", int'(vout.dat.rgb), 'hfff);
    end
    check("flash_frozen_x", int'(target_x), 766);
    pix(0, 0, 1'b0, 1'b0);
    pix(766, 40, 1'b0, 1'b0);
    check("respawn_undrawn", int'(vout.dat.rgb), last_rgb);
    frame();
    check("respawn_x", int'(target_x), 384);
    frame();
    check("respawn_dir", int'(target_x), 386);

    bullet_active = 1'b1;
    bullet_x = 12'(m_x - 4);
    pix(0, 0, 1'b0, 1'b0);
    check("near_miss", int'(hit), 0);
    bullet_x = 12'(m_x - 3);
    pix(0, 0, 1'b0, 1'b0);
    check("edge_hit", int'(hit), 1);
    check("edge_score", int'(score), 2);
    bullet_active = 1'b0;
    for (int n = 0; n < 31; n++) fast_frame();
    check("second_respawn_x", int'(target_x), 384);
    bullet_x = 12'd394;
    pix(0, 0, 1'b0, 1'b0);
    check("inactive_bullet", int'(hit), 0);
    check("inactive_x", int'(target_x), 382);

    bullet_active = 1'b1;
    for (int k = 0; k < 256; k++) begin
      for (int n = 0; n < 32; n++) fast_frame();
    end
    check("score_sat", int'(score), 255);

    fast_frame();
    for (int n = 0; n < 5; n++) fast_frame();
    bullet_active = 1'b0;
    rst_n = 1'b0;
    pix(10, 10, 1'b0, 1'b0);
    check("midflash_score", int'(score), 0);
    check("midflash_x", int'(target_x), 384);
    check("midflash_rgb", int'(vout.dat.rgb), 0);
    check("midflash_hit", int'(hit), 0);
    rst_n = 1'b1;
    frame();
    check("post_reset_move", int'(target_x), 386);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
